// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-segment scanner: scan FSM states and the
// active-low glyph table in a..g order (bit 0 of the [0:6] vector is segment a).
package disp_pkg;

    typedef enum logic [0:0] {
        BLANK  = 1'b0,
        ACTIVE = 1'b1
    } scan_state_t;

    localparam logic [0:6] SEG_BLANK = 7'h7F;

    localparam logic [0:6] GLYPH [0:15] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

endpackage

// File: rtl/nibble_to_seg.sv
// Combinational nibble-to-segment decoder; in decimal mode values above 9 render
// as a blank glyph so the digit stays enabled but shows nothing.
import disp_pkg::*;

module nibble_to_seg (
    input  logic [3:0] nibble,
    input  logic       mode,
    output logic [0:6] seg
);

    assign seg = (!mode && (nibble > 4'd9)) ? SEG_BLANK : GLYPH[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner: per-frame input snapshot,
// blank gap between digit slots, PWM brightness and leading-zero suppression.
import disp_pkg::*;

module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int BLANK_CYC  = 4,
    parameter int ACT_LOG2   = 6,
    parameter int BR_W       = 3
) (
    input  logic                    CLK,
    input  logic                    CLEAR,
    input  logic [4*NUM_DIGITS-1:0] DIGITS,
    input  logic [NUM_DIGITS-1:0]   DP_IN,
    input  logic                    MODE,
    input  logic                    LZ_EN,
    input  logic [BR_W-1:0]         BRIGHT,
    output logic [NUM_DIGITS-1:0]   CAT,
    output logic [0:6]              HEX,
    output logic                    DP,
    output logic                    FRAME
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int BLK_W   = $clog2(BLANK_CYC + 1);
    localparam int CNT_W   = (ACT_LOG2 >= BLK_W) ? ACT_LOG2 : BLK_W;
    localparam int ACT_LEN = 1 << ACT_LOG2;

    scan_state_t            state;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;

    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic                    snap_mode;
    logic                    snap_lz;
    logic [BR_W-1:0]         snap_bright;

    logic                    frame_start;
    logic                    blank_last;
    logic                    act_last;
    logic [3:0]              sel_nibble;
    logic                    sel_dp;
    logic                    sel_supp;
    logic                    zero_above;
    logic [BR_W-1:0]         pwm_code;
    logic                    pwm_lit;
    logic                    drive;
    logic [0:6]              glyph;
    logic [NUM_DIGITS-1:0]   cat_next;

    assign frame_start = (state == BLANK) && (cnt == '0) && (idx == '0);
    assign blank_last  = (cnt == CNT_W'(BLANK_CYC - 1));
    assign act_last    = (cnt == CNT_W'(ACT_LEN - 1));

    always_ff @(posedge CLK or negedge CLEAR) begin
        if (!CLEAR) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                BLANK: begin
                    if (blank_last) begin
                        state <= ACTIVE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ACTIVE: begin
                    if (act_last) begin
                        state <= BLANK;
                        cnt   <= '0;
                        idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Everything the display shows comes from this frame-aligned copy.
    always_ff @(posedge CLK or negedge CLEAR) begin
        if (!CLEAR) begin
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_mode   <= 1'b0;
            snap_lz     <= 1'b0;
            snap_bright <= '0;
        end else if (frame_start) begin
            snap_digits <= DIGITS;
            snap_dp     <= DP_IN;
            snap_mode   <= MODE;
            snap_lz     <= LZ_EN;
            snap_bright <= BRIGHT;
        end
    end

    // Walk from the top digit down; a digit is a leading zero while every nibble
    // at or above it is zero. Digit 0 is never part of that run.
    always_comb begin
        sel_nibble = snap_digits[3:0];
        sel_dp     = snap_dp[0];
        sel_supp   = 1'b0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (snap_digits[4*i +: 4] == 4'h0);
            if (idx == IDX_W'(i)) begin
                sel_nibble = snap_digits[4*i +: 4];
                sel_dp     = snap_dp[i];
                sel_supp   = snap_lz & zero_above;
            end
        end
    end

    nibble_to_seg u_dec (
        .nibble (sel_nibble),
        .mode   (snap_mode),
        .seg    (glyph)
    );

    assign pwm_code = cnt[ACT_LOG2-1 -: BR_W];
    assign pwm_lit  = (snap_bright == {BR_W{1'b1}}) || (pwm_code < snap_bright);
    assign drive    = (state == ACTIVE) && pwm_lit && !sel_supp;
    assign cat_next = drive ? ~(NUM_DIGITS'(1) << idx) : {NUM_DIGITS{1'b1}};

    always_ff @(posedge CLK or negedge CLEAR) begin
        if (!CLEAR) begin
            CAT   <= {NUM_DIGITS{1'b1}};
            HEX   <= SEG_BLANK;
            DP    <= 1'b1;
            FRAME <= 1'b0;
        end else begin
            CAT   <= cat_next;
            HEX   <= drive ? glyph : SEG_BLANK;
            DP    <= drive ? ~sel_dp : 1'b1;
            FRAME <= frame_start;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at default parameters (slot 68, frame 272).
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

    logic        CLK;
    logic        CLEAR;
    logic [15:0] DIGITS;
    logic [3:0]  DP_IN;
    logic        MODE;
    logic        LZ_EN;
    logic [2:0]  BRIGHT;
    logic [3:0]  CAT;
    logic [0:6]  HEX;
    logic        DP;
    logic        FRAME;

    int errors = 0;
    int checks = 0;

    // per-slot observations
    int         obs_blank, obs_lit, obs_dark_at, obs_dark_bad, obs_strays;
    logic       obs_frame0, obs_dp;
    logic [3:0] obs_cat;
    logic [0:6] obs_hex;

    seg_scan_ctrl dut (
        .CLK    (CLK),
        .CLEAR  (CLEAR),
        .DIGITS (DIGITS),
        .DP_IN  (DP_IN),
        .MODE   (MODE),
        .LZ_EN  (LZ_EN),
        .BRIGHT (BRIGHT),
        .CAT    (CAT),
        .HEX    (HEX),
        .DP     (DP),
        .FRAME  (FRAME)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Watches one 68-cycle slot starting at its first blank cycle on the pins.
    task automatic observe_slot(input int change_at, input logic [15:0] new_digits);
        obs_blank = 0; obs_lit = 0; obs_dark_at = -1; obs_dark_bad = 0; obs_strays = 0;
        obs_frame0 = FRAME; obs_cat = 4'hF; obs_hex = 7'h7F; obs_dp = 1'b1;
        for (int k = 0; k < 68; k++) begin
            if (k == change_at) DIGITS = new_digits;
            if (k > 0 && FRAME === 1'b1) obs_strays++;
            if (k < 4) begin
                if (CAT === 4'hF && HEX === 7'h7F && DP === 1'b1) obs_blank++;
            end else if (CAT !== 4'hF) begin
                obs_lit++;
                obs_cat = CAT; obs_hex = HEX; obs_dp = DP;
            end else begin
                if (obs_dark_at < 0) obs_dark_at = k - 4;
                if (HEX !== 7'h7F || DP !== 1'b1) obs_dark_bad++;
            end
            tick();
        end
        if (obs_dark_at < 0) obs_dark_at = 64;
    endtask

    task automatic sync_frame();
        int n;
        n = 0;
        tick();
        while (FRAME !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (FRAME !== 1'b1) begin
            errors++;
            $display("FAIL sync_frame: FRAME=%b after %0d cycles, expected 1", FRAME, n);
        end
    endtask

    task automatic test_reset();
        CLEAR = 1'b1;
        DIGITS = 16'h1234; DP_IN = 4'h0; MODE = 1'b1; LZ_EN = 1'b0; BRIGHT = 3'd7;
        #2 CLEAR = 1'b0;
        repeat (3) tick();
        checks++;
        if ({CAT, HEX, DP, FRAME} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: CAT=%h HEX=%b DP=%b FRAME=%b, expected F 1111111 1 0",
                     CAT, HEX, DP, FRAME);
        end
        #3 CLEAR = 1'b1;
        tick();
        checks++;
        if (FRAME !== 1'b1 || CAT !== 4'hF) begin
            errors++;
            $display("FAIL reset_release: FRAME=%b CAT=%h, expected 1 F", FRAME, CAT);
        end
    endtask

    task automatic test_basic();
        logic [3:0] ec [4];
        logic [0:6] eh [4];
        ec = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        eh = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
        for (int s = 0; s < 4; s++) begin
            observe_slot(-1, 16'h0);
            checks++;
            if (obs_lit !== 64 || {obs_cat, obs_hex, obs_dp} !== {ec[s], eh[s], 1'b1}) begin
                errors++;
                $display("FAIL basic_slot%0d: lit=%0d CAT=%b HEX=%b DP=%b, expected 64 %b %b 1",
                         s, obs_lit, obs_cat, obs_hex, obs_dp, ec[s], eh[s]);
            end
            checks++;
            if (obs_blank !== 4 || obs_dark_bad !== 0 || obs_strays !== 0 || obs_frame0 !== (s == 0)) begin
                errors++;
                $display("FAIL basic_shape%0d: blank=%0d dark_bad=%0d strays=%0d frame0=%b, expected 4 0 0 %0d",
                         s, obs_blank, obs_dark_bad, obs_strays, obs_frame0, (s == 0));
            end
        end
        checks++;
        if (FRAME !== 1'b1) begin
            errors++;
            $display("FAIL frame_period: FRAME=%b at cycle 272, expected 1", FRAME);
        end
    endtask

    task automatic test_lz();
        int         el [4];
        logic [3:0] ec [4];
        logic [0:6] eh [4];
        DIGITS = 16'h0050; LZ_EN = 1'b1; DP_IN = 4'b1000;
        sync_frame();
        el = '{64, 64, 0, 0};
        ec = '{4'b1110, 4'b1101, 4'hF, 4'hF};
        eh = '{7'b0000001, 7'b0100100, 7'h7F, 7'h7F};
        for (int s = 0; s < 4; s++) begin
            observe_slot(-1, 16'h0);
            checks++;
            if (obs_lit !== el[s] || {obs_cat, obs_hex, obs_dp} !== {ec[s], eh[s], 1'b1} || obs_dark_bad !== 0) begin
                errors++;
                $display("FAIL lz_slot%0d: lit=%0d CAT=%b HEX=%b DP=%b dark_bad=%0d, expected %0d %b %b 1 0",
                         s, obs_lit, obs_cat, obs_hex, obs_dp, obs_dark_bad, el[s], ec[s], eh[s]);
            end
        end
        DIGITS = 16'h0000; DP_IN = 4'h0;
        sync_frame();
        for (int s = 0; s < 4; s++) begin
            observe_slot(-1, 16'h0);
            checks++;
            if (obs_lit !== ((s == 0) ? 64 : 0) || (s == 0 && obs_hex !== 7'b0000001)) begin
                errors++;
                $display("FAIL lz_zero_slot%0d: lit=%0d HEX=%b, expected %0d 0000001",
                         s, obs_lit, obs_hex, (s == 0) ? 64 : 0);
            end
        end
        LZ_EN = 1'b0;
    endtask

    task automatic test_pwm();
        logic [2:0] br [3];
        int         el [3];
        br = '{3'd2, 3'd6, 3'd0};
        el = '{16, 48, 0};
        DIGITS = 16'h1234;
        for (int b = 0; b < 3; b++) begin
            BRIGHT = br[b];
            sync_frame();
            for (int s = 0; s < 4; s++) begin
                observe_slot(-1, 16'h0);
                checks++;
                if (obs_lit !== el[b] || obs_dark_at !== el[b] || obs_dark_bad !== 0) begin
                    errors++;
                    $display("FAIL pwm_br%0d_slot%0d: lit=%0d first_dark=%0d dark_bad=%0d, expected %0d %0d 0",
                             br[b], s, obs_lit, obs_dark_at, obs_dark_bad, el[b], el[b]);
                end
            end
        end
        BRIGHT = 3'd7;
    endtask

    task automatic test_snapshot();
        logic [0:6] old_h [4];
        logic [0:6] new_h [4];
        old_h = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
        new_h = '{7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100};
        DIGITS = 16'h1234;
        sync_frame();
        // DIGITS changes 100 cycles into the frame (slot 1 starts at 68).
        for (int s = 0; s < 4; s++) begin
            observe_slot((s == 1) ? 32 : -1, 16'h5678);
            checks++;
            if (obs_lit !== 64 || obs_hex !== old_h[s]) begin
                errors++;
                $display("FAIL snap_hold_slot%0d: lit=%0d HEX=%b, expected 64 %b", s, obs_lit, obs_hex, old_h[s]);
            end
        end
        for (int s = 0; s < 4; s++) begin
            observe_slot(-1, 16'h0);
            checks++;
            if (obs_lit !== 64 || obs_hex !== new_h[s] || obs_frame0 !== (s == 0)) begin
                errors++;
                $display("FAIL snap_new_slot%0d: lit=%0d HEX=%b frame0=%b, expected 64 %b %0d",
                         s, obs_lit, obs_hex, obs_frame0, new_h[s], (s == 0));
            end
        end
    endtask

    task automatic test_glyph_dp();
        logic [3:0] ec [4];
        logic [0:6] eh [4];
        logic       ed [4];
        DIGITS = 16'h12B4; MODE = 1'b1; DP_IN = 4'b0100;
        ec = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        eh = '{7'b1001100, 7'b1100000, 7'b0010010, 7'b1001111};
        ed = '{1'b1, 1'b1, 1'b0, 1'b1};
        sync_frame();
        for (int s = 0; s < 4; s++) begin
            observe_slot(-1, 16'h0);
            checks++;
            if (obs_lit !== 64 || {obs_cat, obs_hex, obs_dp} !== {ec[s], eh[s], ed[s]}) begin
                errors++;
                $display("FAIL hex_dp_slot%0d: lit=%0d CAT=%b HEX=%b DP=%b, expected 64 %b %b %b",
                         s, obs_lit, obs_cat, obs_hex, obs_dp, ec[s], eh[s], ed[s]);
            end
        end
        MODE = 1'b0; DP_IN = 4'h0;
        eh[1] = 7'h7F;
        ed[2] = 1'b1;
        sync_frame();
        for (int s = 0; s < 4; s++) begin
            observe_slot(-1, 16'h0);
            checks++;
            if (obs_lit !== 64 || {obs_cat, obs_hex, obs_dp} !== {ec[s], eh[s], ed[s]}) begin
                errors++;
                $display("FAIL dec_slot%0d: lit=%0d CAT=%b HEX=%b DP=%b, expected 64 %b %b %b",
                         s, obs_lit, obs_cat, obs_hex, obs_dp, ec[s], eh[s], ed[s]);
            end
        end
        MODE = 1'b1;
    endtask

    task automatic test_reset_mid();
        DIGITS = 16'h1234;
        sync_frame();
        observe_slot(-1, 16'h0);
        observe_slot(-1, 16'h0);
        repeat (14) tick();
        checks++;
        if (CAT !== 4'b1011) begin
            errors++;
            $display("FAIL mid_pre: CAT=%b, expected 1011", CAT);
        end
        #1 CLEAR = 1'b0;
        #1;
        checks++;
        if ({CAT, HEX, DP, FRAME} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mid_async: CAT=%b HEX=%b DP=%b FRAME=%b, expected 1111 1111111 1 0",
                     CAT, HEX, DP, FRAME);
        end
        repeat (2) tick();
        #3 CLEAR = 1'b1;
        tick();
        checks++;
        if (FRAME !== 1'b1 || CAT !== 4'hF) begin
            errors++;
            $display("FAIL mid_release: FRAME=%b CAT=%b, expected 1 1111", FRAME, CAT);
        end
        observe_slot(-1, 16'h0);
        checks++;
        if (obs_lit !== 64 || obs_cat !== 4'b1110 || obs_hex !== 7'b1001100 || obs_blank !== 4) begin
            errors++;
            $display("FAIL mid_digit0: lit=%0d CAT=%b HEX=%b blank=%0d, expected 64 1110 1001100 4",
                     obs_lit, obs_cat, obs_hex, obs_blank);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lz();
        test_pwm();
        test_snapshot();
        test_glyph_dp();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
